// File: rtl/verin_adc_capture_if.sv
// Purpose : signal bundle between the verin ADC capture block and its surroundings
//           (SPI pins to the MCP3201-style ADC, control input, published results).
// Latency : n/a (wires only).
// Backpressure: none; results are presented with a one-cycle data_valid strobe.
// Ports (master = capture block side):
//   enable      in   run periodic conversions
//   adc_miso    in   ADC serial data
//   adc_cs_n    out  ADC chip select, active low
//   adc_sclk    out  SPI clock, idle low
//   data_out    out  8-bit position byte (data_raw[11:4]) for the PIO in_port
//   data_raw    out  full 12-bit last conversion
//   data_valid  out  1-cycle pulse when results update
//   frame_err   out  null bit of last frame was 1
//   busy        out  conversion in progress
interface verin_adc_capture_if;
   logic        enable;
   logic        adc_miso;
   logic        adc_cs_n;
   logic        adc_sclk;
   logic [7:0]  data_out;
   logic [11:0] data_raw;
   logic        data_valid;
   logic        frame_err;
   logic        busy;

   modport master (
      input  enable, adc_miso,
      output adc_cs_n, adc_sclk, data_out, data_raw, data_valid, frame_err, busy
   );

   modport slave (
      output enable, adc_miso,
      input  adc_cs_n, adc_sclk, data_out, data_raw, data_valid, frame_err, busy
   );
endinterface

// File: rtl/verin_adc_capture.sv
// Purpose : periodic 15-clock SPI read of a 12-bit ADC giving the actuator position.
// Latency : data_valid rises 32*CLK_DIV cycles after the edge that pulls adc_cs_n low.
// Backpressure: none; results are held until the next frame overwrites them.
// Ports: clk, reset_n (async, active low), bus (verin_adc_capture_if.master):
//   enable/adc_miso in; adc_cs_n/adc_sclk/data_out/data_raw/data_valid/frame_err/busy out.
module verin_adc_capture #(
   parameter int CLK_DIV       = 25,
   parameter int SAMPLE_PERIOD = 5000
) (
   input  logic                clk,
   input  logic                reset_n,
   verin_adc_capture_if.master bus
);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int PER_W = $clog2(SAMPLE_PERIOD);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   state_t            state_q, state_d;
   logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   // Only the last 13 received bits are kept: the two sample-clock bits
   // simply fall off the top, leaving {null, B11..B0}.
   logic [12:0]       shreg_q, shreg_d;
   logic              cs_n_q, cs_n_d;
   logic              sclk_q, sclk_d;
   logic [11:0]       data_raw_q, data_raw_d;
   logic              frame_err_q, frame_err_d;
   logic              data_valid_q, data_valid_d;
   logic              tick, div_end;

   always_comb begin
      state_d      = state_q;
      div_cnt_d    = div_end_next(div_cnt_q);
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      cs_n_d       = cs_n_q;
      sclk_d       = sclk_q;
      data_raw_d   = data_raw_q;
      frame_err_d  = frame_err_q;
      data_valid_d = 1'b0;

      tick    = bus.enable && (per_cnt_q == PER_LAST);
      div_end = (div_cnt_q == DIV_LAST);

      if (!bus.enable || tick) per_cnt_d = '0;
      else                     per_cnt_d = per_cnt_q + PER_W'(1);

      case (state_q)
         IDLE: begin
            div_cnt_d = '0;
            if (tick) begin
               cs_n_d  = 1'b0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (div_end) begin
               sclk_d    = 1'b1;
               bit_cnt_d = 4'd0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (div_end) begin
               sclk_d = ~sclk_q;
               if (sclk_q) begin
                  // Falling edge: ADC data has been stable for the whole high phase.
                  shreg_d   = {shreg_q[11:0], bus.adc_miso};
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd14) begin
                     cs_n_d  = 1'b1;
                     state_d = HOLD;
                  end
               end
            end
         end
         HOLD: begin
            // Two half-periods: the 15th SCLK low phase, then CS-high guard.
            // bit_cnt is 15 on entry and marks the first half.
            if (div_end) begin
               if (bit_cnt_q == 4'd15) begin
                  bit_cnt_d = 4'd0;
               end else begin
                  data_raw_d   = shreg_q[11:0];
                  frame_err_d  = shreg_q[12];
                  data_valid_d = 1'b1;
                  state_d      = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   function automatic logic [DIV_W-1:0] div_end_next(input logic [DIV_W-1:0] cnt);
      return (cnt == DIV_LAST) ? '0 : cnt + DIV_W'(1);
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         per_cnt_q    <= '0;
         div_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         cs_n_q       <= 1'b1;
         sclk_q       <= 1'b0;
         data_raw_q   <= '0;
         frame_err_q  <= 1'b0;
         data_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         per_cnt_q    <= per_cnt_d;
         div_cnt_q    <= div_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         cs_n_q       <= cs_n_d;
         sclk_q       <= sclk_d;
         data_raw_q   <= data_raw_d;
         frame_err_q  <= frame_err_d;
         data_valid_q <= data_valid_d;
      end
   end

   assign bus.adc_cs_n   = cs_n_q;
   assign bus.adc_sclk   = sclk_q;
   assign bus.data_raw   = data_raw_q;
   assign bus.data_out   = data_raw_q[11:4];
   assign bus.frame_err  = frame_err_q;
   assign bus.data_valid = data_valid_q;
   assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_verin_adc_capture.sv
// Purpose : self-checking bench for verin_adc_capture with an ADC model and SPI timing monitor.
// Latency : expects data_valid 32*CLK_DIV cycles after adc_cs_n falls.
// Backpressure: none.
module tb_verin_adc_capture;
   localparam int CLK_DIV       = 2;
   localparam int SAMPLE_PERIOD = 100;
   localparam int FRAME_LAT     = 32 * CLK_DIV;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   verin_adc_capture_if ifc();

   verin_adc_capture #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SAMPLE_PERIOD)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifc)
   );

   always #5 clk = ~clk;

   // ADC model: frame bit 14 goes out first, next bit after each SCLK fall.
   logic [14:0] adc_frame = '0;
   int          adc_idx = 0;
   logic        a_cs = 1'b1, a_sclk = 1'b0;
   always @(posedge clk) begin
      #1;
      if (a_cs && !ifc.adc_cs_n)         adc_idx = 0;
      else if (a_sclk && !ifc.adc_sclk)  adc_idx = adc_idx + 1;
      ifc.adc_miso = (!ifc.adc_cs_n && adc_idx < 15) ? adc_frame[14 - adc_idx] : 1'b0;
      a_cs   = ifc.adc_cs_n;
      a_sclk = ifc.adc_sclk;
   end

   // Timing monitor: cyc equals the number of rising clk edges so far.
   int   cyc = 0;
   logic m_cs = 1'b1, m_sclk = 1'b0, m_dv = 1'b0;
   int   t_csfall = 0, t_first_rise = 0, t_last_fall = 0, t_csrise = 0, t_dv = 0, t_edge = 0;
   int   n_rise = 0, rise_total = 0, csfall_count = 0, dv_count = 0, dv_long = 0, cs_gap = 0;
   int   hi_min = 0, hi_max = 0, lo_min = 0, lo_max = 0;
   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      if (m_cs && !ifc.adc_cs_n) begin
         cs_gap = cyc - t_csrise;
         t_csfall = cyc; n_rise = 0; csfall_count++;
         hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
      end
      if (!m_sclk && ifc.adc_sclk) begin
         n_rise++; rise_total++;
         if (n_rise == 1) t_first_rise = cyc;
         else begin
            if (cyc - t_edge < lo_min) lo_min = cyc - t_edge;
            if (cyc - t_edge > lo_max) lo_max = cyc - t_edge;
         end
         t_edge = cyc;
      end
      if (m_sclk && !ifc.adc_sclk) begin
         if (cyc - t_edge < hi_min) hi_min = cyc - t_edge;
         if (cyc - t_edge > hi_max) hi_max = cyc - t_edge;
         t_edge = cyc; t_last_fall = cyc;
      end
      if (!m_cs && ifc.adc_cs_n) t_csrise = cyc;
      if (ifc.data_valid) begin
         dv_count++; t_dv = cyc;
         if (m_dv) dv_long++;
      end
      m_cs = ifc.adc_cs_n; m_sclk = ifc.adc_sclk; m_dv = ifc.data_valid;
   end

   task automatic load_frame(input logic [11:0] v, input logic nb);
      logic [1:0] sc;
      sc = 2'($urandom_range(0, 3));
      adc_frame = {sc, nb, v};
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      ifc.enable = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_dv(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (ifc.data_valid) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_rises(input int n, input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (!ifc.adc_cs_n && n_rise >= n) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      ifc.enable = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (ifc.adc_cs_n !== 1'b1) begin failures++; $display("FAIL rst_cs_n got=%b exp=1", ifc.adc_cs_n); end
      checks++; if (ifc.adc_sclk !== 1'b0) begin failures++; $display("FAIL rst_sclk got=%b exp=0", ifc.adc_sclk); end
      checks++; if (ifc.data_out !== 8'h00) begin failures++; $display("FAIL rst_data_out got=%h exp=00", ifc.data_out); end
      checks++; if (ifc.data_raw !== 12'h000) begin failures++; $display("FAIL rst_data_raw got=%h exp=000", ifc.data_raw); end
      checks++; if (ifc.data_valid !== 1'b0) begin failures++; $display("FAIL rst_data_valid got=%b exp=0", ifc.data_valid); end
      checks++; if (ifc.frame_err !== 1'b0) begin failures++; $display("FAIL rst_frame_err got=%b exp=0", ifc.frame_err); end
      checks++; if (ifc.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", ifc.busy); end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      bit ok;
      int c0, csf1;
      logic [11:0] v;
      do_reset();
      v = 12'hA5C;
      load_frame(v, 1'b0);
      ifc.enable = 1'b1; c0 = cyc;
      wait_dv(200, ok);
      checks++; if (!ok) begin failures++; $display("FAIL single_dv_timeout got=none exp=pulse"); end
      checks++; if (t_csfall !== c0 + SAMPLE_PERIOD) begin failures++; $display("FAIL first_tick got=%0d exp=%0d", t_csfall - c0, SAMPLE_PERIOD); end
      checks++; if (t_dv - t_csfall !== FRAME_LAT) begin failures++; $display("FAIL latency got=%0d exp=%0d", t_dv - t_csfall, FRAME_LAT); end
      checks++; if (ifc.data_raw !== v) begin failures++; $display("FAIL single_raw got=%h exp=%h", ifc.data_raw, v); end
      checks++; if (ifc.data_out !== 8'(v >> 4)) begin failures++; $display("FAIL single_out got=%h exp=%h", ifc.data_out, 8'(v >> 4)); end
      checks++; if (ifc.frame_err !== 1'b0) begin failures++; $display("FAIL single_ferr got=%b exp=0", ifc.frame_err); end
      checks++; if (ifc.busy !== 1'b0) begin failures++; $display("FAIL busy_at_dv got=%b exp=0", ifc.busy); end
      checks++; if (n_rise !== 15) begin failures++; $display("FAIL sclk_rises got=%0d exp=15", n_rise); end
      checks++; if (t_first_rise - t_csfall !== CLK_DIV) begin failures++; $display("FAIL cs_setup got=%0d exp=%0d", t_first_rise - t_csfall, CLK_DIV); end
      checks++; if (hi_min !== CLK_DIV || hi_max !== CLK_DIV) begin failures++; $display("FAIL sclk_high got=%0d..%0d exp=%0d", hi_min, hi_max, CLK_DIV); end
      checks++; if (lo_min !== CLK_DIV || lo_max !== CLK_DIV) begin failures++; $display("FAIL sclk_low got=%0d..%0d exp=%0d", lo_min, lo_max, CLK_DIV); end
      checks++; if (t_csrise - t_last_fall !== 0) begin failures++; $display("FAIL cs_hold got=%0d exp=0", t_csrise - t_last_fall); end
      csf1 = t_csfall;
      v = 12'($urandom);
      load_frame(v, 1'b0);
      wait_dv(200, ok);
      checks++; if (!ok) begin failures++; $display("FAIL second_dv_timeout got=none exp=pulse"); end
      checks++; if (t_csfall !== csf1 + SAMPLE_PERIOD) begin failures++; $display("FAIL period got=%0d exp=%0d", t_csfall - csf1, SAMPLE_PERIOD); end
      checks++; if (cs_gap < 36) begin failures++; $display("FAIL cs_high_gap got=%0d exp>=36", cs_gap); end
      checks++; if (ifc.data_raw !== v) begin failures++; $display("FAIL second_raw got=%h exp=%h", ifc.data_raw, v); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int dv0, dl0;
      logic [11:0] vals[5];
      vals[0] = 12'h000; vals[1] = 12'hFFF;
      for (int i = 2; i < 5; i++) vals[i] = 12'($urandom);
      for (int i = 0; i < 5; i++) begin
         load_frame(vals[i], 1'b0);
         dv0 = dv_count; dl0 = dv_long;
         wait_dv(200, ok);
         checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout[%0d] got=none exp=pulse", i); end
         checks++; if (ifc.data_out !== 8'(vals[i] >> 4)) begin failures++; $display("FAIL b2b_out[%0d] got=%h exp=%h", i, ifc.data_out, 8'(vals[i] >> 4)); end
         repeat (20) @(negedge clk);
         checks++; if (ifc.data_raw !== vals[i]) begin failures++; $display("FAIL b2b_hold[%0d] got=%h exp=%h", i, ifc.data_raw, vals[i]); end
         checks++; if (dv_count !== dv0 + 1 || dv_long !== dl0) begin failures++; $display("FAIL b2b_pulse[%0d] got=%0d/%0d exp=1/0", i, dv_count - dv0, dv_long - dl0); end
      end
   endtask

   task automatic test_frame_err();
      bit ok;
      logic [11:0] v;
      load_frame(12'h123, 1'b1);
      wait_dv(200, ok);
      checks++; if (!ok) begin failures++; $display("FAIL ferr_timeout got=none exp=pulse"); end
      checks++; if (ifc.frame_err !== 1'b1) begin failures++; $display("FAIL ferr_set got=%b exp=1", ifc.frame_err); end
      checks++; if (ifc.data_raw !== 12'h123) begin failures++; $display("FAIL ferr_raw got=%h exp=123", ifc.data_raw); end
      v = 12'($urandom);
      load_frame(v, 1'b0);
      wait_dv(200, ok);
      checks++; if (ifc.frame_err !== 1'b0 || !ok) begin failures++; $display("FAIL ferr_clear got=%b exp=0", ifc.frame_err); end
      checks++; if (ifc.data_raw !== v) begin failures++; $display("FAIL ferr_next_raw got=%h exp=%h", ifc.data_raw, v); end
   endtask

   task automatic test_enable();
      bit ok;
      int cf0, dv0, r0, c0;
      logic [11:0] v;
      do_reset();
      cf0 = csfall_count; dv0 = dv_count; r0 = rise_total;
      repeat (1000) @(negedge clk);
      checks++; if (csfall_count !== cf0 || ifc.adc_cs_n !== 1'b1) begin failures++; $display("FAIL en0_cs got=%0d falls exp=0", csfall_count - cf0); end
      checks++; if (rise_total !== r0 || ifc.adc_sclk !== 1'b0) begin failures++; $display("FAIL en0_sclk got=%0d rises exp=0", rise_total - r0); end
      checks++; if (dv_count !== dv0) begin failures++; $display("FAIL en0_dv got=%0d exp=0", dv_count - dv0); end
      v = 12'($urandom);
      load_frame(v, 1'b0);
      ifc.enable = 1'b1;
      wait_rises(5, 200, ok);
      checks++; if (!ok) begin failures++; $display("FAIL en_shift_timeout got=none exp=shift"); end
      ifc.enable = 1'b0;
      wait_dv(200, ok);
      checks++; if (!ok || ifc.data_raw !== v) begin failures++; $display("FAIL en_drop_publish got=%h exp=%h", ifc.data_raw, v); end
      cf0 = csfall_count; dv0 = dv_count;
      repeat (300) @(negedge clk);
      checks++; if (csfall_count !== cf0 || dv_count !== dv0) begin failures++; $display("FAIL en_drop_quiet got=%0d/%0d exp=0/0", csfall_count - cf0, dv_count - dv0); end
      v = 12'($urandom);
      load_frame(v, 1'b0);
      ifc.enable = 1'b1; c0 = cyc;
      wait_dv(200, ok);
      checks++; if (!ok || t_csfall !== c0 + SAMPLE_PERIOD) begin failures++; $display("FAIL en_fresh_period got=%0d exp=%0d", t_csfall - c0, SAMPLE_PERIOD); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int dv0, c0;
      logic [11:0] v;
      do_reset();
      load_frame(12'($urandom), 1'b0);
      ifc.enable = 1'b1;
      wait_rises(8, 200, ok);
      checks++; if (!ok || ifc.busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", ifc.busy); end
      dv0 = dv_count;
      reset_n = 1'b0;
      #1;
      checks++; if (ifc.adc_cs_n !== 1'b1 || ifc.adc_sclk !== 1'b0) begin failures++; $display("FAIL mid_rst_pins got=%b%b exp=10", ifc.adc_cs_n, ifc.adc_sclk); end
      checks++; if (ifc.data_out !== 8'h00 || ifc.busy !== 1'b0) begin failures++; $display("FAIL mid_rst_out got=%h/%b exp=00/0", ifc.data_out, ifc.busy); end
      ifc.enable = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (150) @(negedge clk);
      checks++; if (dv_count !== dv0 || ifc.data_raw !== 12'h000) begin failures++; $display("FAIL mid_no_publish got=%0d/%h exp=0/000", dv_count - dv0, ifc.data_raw); end
      v = 12'($urandom);
      load_frame(v, 1'b0);
      ifc.enable = 1'b1; c0 = cyc;
      wait_dv(200, ok);
      checks++; if (!ok || ifc.data_raw !== v) begin failures++; $display("FAIL mid_recover got=%h exp=%h", ifc.data_raw, v); end
      checks++; if (t_csfall !== c0 + SAMPLE_PERIOD) begin failures++; $display("FAIL mid_recover_tick got=%0d exp=%0d", t_csfall - c0, SAMPLE_PERIOD); end
   endtask

   initial begin
      ifc.enable = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_frame_err();
      test_enable();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
